// File: rtl/controle_somador_4bits.sv
// Accumulator calculator controller: sequences an external 4-bit adder/subtractor and shows ACC as BCD digits.
// Optional build macro CTRL_SATURATE_EN clamps ACC to 15 (add) or 0 (sub) on carry/borrow instead of wrapping.
//
// state  | meaning
// S_IDLE | waiting for an ENTER rising edge
// S_EXEC | adder operands held stable for SETTLE_CYCLES cycles
// S_CAPT | adder result captured into ACC/OVF, DONE raised
module controle_somador_4bits #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       i_clock_50,
    input  logic       i_rst,
    input  logic [3:0] i_sw,
    input  logic       i_op,
    input  logic       i_enter,
    input  logic       i_clear,
    output logic [3:0] o_add_a,
    output logic [3:0] o_add_b,
    output logic       o_add_te,
    input  logic [4:0] i_add_res,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ovf,
    output logic [3:0] o_dez,
    output logic [3:0] o_uni
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_enter_q;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_acc;
    logic [3:0]    r_b;
    logic          r_op;
    logic          r_ovf;
    logic          r_done;

    logic          w_start;
    logic          w_load;
    logic          w_capt;
    logic [3:0]    w_result;

    assign w_start = i_enter & ~r_enter_q;

    always_ff @(posedge i_clock_50) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_next = S_EXEC;
                S_EXEC:  if (r_cnt == '0) w_next = S_CAPT;
                S_CAPT:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (r_state != S_IDLE);
        w_load = (r_state == S_IDLE) & w_start & ~i_clear;
        w_capt = (r_state == S_CAPT) & ~i_clear;
    end

`ifdef CTRL_SATURATE_EN
    // Borrow on subtract clamps to 0, carry on add clamps to 15.
    assign w_result = i_add_res[4] ? (r_op ? 4'd0 : 4'd15) : i_add_res[3:0];
`else
    assign w_result = i_add_res[3:0];
`endif

    always_ff @(posedge i_clock_50) begin
        if (i_rst) begin
            r_enter_q <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= 4'd0;
            r_b       <= 4'd0;
            r_op      <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_enter_q <= i_enter;
            r_done    <= w_capt;
            if (w_load) begin
                r_b   <= i_sw;
                r_op  <= i_op;
                r_cnt <= CNT_LOAD;
            end else if (r_state == S_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (i_clear) begin
                r_acc <= 4'd0;
                r_ovf <= 1'b0;
            end else if (w_capt) begin
                r_acc <= w_result;
                r_ovf <= i_add_res[4];
            end
        end
    end

    assign o_add_a  = r_acc;
    assign o_add_b  = r_b;
    assign o_add_te = r_op;
    assign o_done   = r_done;
    assign o_ovf    = r_ovf;

    // ACC never exceeds 15, so the tens digit is 0 or 1.
    always_comb begin
        if (r_acc >= 4'd10) begin
            o_dez = 4'd1;
            o_uni = r_acc - 4'd10;
        end else begin
            o_dez = 4'd0;
            o_uni = r_acc;
        end
    end

endmodule

// File: tb/tb_controle_somador_4bits.sv
// Bench for controle_somador_4bits: two instances (SETTLE_CYCLES 1 and 3) share stimulus and are checked
// every cycle against a cycle-count reference model, plus directed scenario checks.
module tb_controle_somador_4bits;

`ifdef CTRL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, enter, clear, op;
    logic [3:0] sw;

    logic [3:0] a1, b1, dez1, uni1, a3, b3, dez3, uni3;
    logic       te1, busy1, done1, ovf1, te3, busy3, done3, ovf3;
    logic [4:0] res1, res3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External adder: 5-bit sum for add, 5-bit difference (bit4 = borrow) for subtract.
    assign res1 = te1 ? ({1'b0, a1} - {1'b0, b1}) : ({1'b0, a1} + {1'b0, b1});
    assign res3 = te3 ? ({1'b0, a3} - {1'b0, b3}) : ({1'b0, a3} + {1'b0, b3});

    controle_somador_4bits #(.SETTLE_CYCLES(1)) u_dut1 (
        .i_clock_50(clk), .i_rst(rst), .i_sw(sw), .i_op(op), .i_enter(enter), .i_clear(clear),
        .o_add_a(a1), .o_add_b(b1), .o_add_te(te1), .i_add_res(res1),
        .o_busy(busy1), .o_done(done1), .o_ovf(ovf1), .o_dez(dez1), .o_uni(uni1)
    );

    controle_somador_4bits #(.SETTLE_CYCLES(3)) u_dut3 (
        .i_clock_50(clk), .i_rst(rst), .i_sw(sw), .i_op(op), .i_enter(enter), .i_clear(clear),
        .o_add_a(a3), .o_add_b(b3), .o_add_te(te3), .i_add_res(res3),
        .o_busy(busy3), .o_done(done3), .o_ovf(ovf3), .o_dez(dez3), .o_uni(uni3)
    );

    // Reference model: an operation started at cycle c completes at cycle c + settle + 1.
    int settle [2] = '{1, 3};
    int m_acc  [2];
    int m_ovf  [2];
    int m_busy [2];
    int m_done [2];
    int m_b    [2];
    int m_op   [2];
    int m_tend [2];
    int cyc = 0;
    bit m_enq = 1'b0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit start;
        int r;
        cyc++;
        start = enter && !m_enq;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_acc[d] = 0; m_ovf[d] = 0; m_busy[d] = 0; m_done[d] = 0; m_b[d] = 0; m_op[d] = 0;
            end else if (clear) begin
                m_acc[d] = 0; m_ovf[d] = 0; m_busy[d] = 0; m_done[d] = 0;
            end else if (m_busy[d] != 0 && cyc == m_tend[d]) begin
                if (m_op[d] == 0) begin
                    r = m_acc[d] + m_b[d];
                    m_ovf[d] = (r > 15) ? 1 : 0;
                    m_acc[d] = (SAT && m_ovf[d] != 0) ? 15 : r % 16;
                end else begin
                    m_ovf[d] = (m_acc[d] < m_b[d]) ? 1 : 0;
                    m_acc[d] = (SAT && m_ovf[d] != 0) ? 0 : (m_acc[d] - m_b[d] + 16) % 16;
                end
                m_busy[d] = 0;
                m_done[d] = 1;
            end else begin
                m_done[d] = 0;
                if (m_busy[d] == 0 && start) begin
                    m_busy[d] = 1;
                    m_b[d]    = sw;
                    m_op[d]   = op;
                    m_tend[d] = cyc + settle[d] + 1;
                end
            end
        end
        m_enq = rst ? 1'b0 : enter;
    endtask

    task automatic check_dut(input int d, input logic [3:0] a, input logic [3:0] b, input logic te,
                             input logic busy, input logic done, input logic ovf,
                             input logic [3:0] dez, input logic [3:0] uni);
        string p;
        p = (d == 0) ? "s1" : "s3";
        check_val({p, ".acc"},  a,    m_acc[d]);
        check_val({p, ".addb"}, b,    m_b[d]);
        check_val({p, ".te"},   te,   m_op[d]);
        check_val({p, ".busy"}, busy, m_busy[d]);
        check_val({p, ".done"}, done, m_done[d]);
        check_val({p, ".ovf"},  ovf,  m_ovf[d]);
        check_val({p, ".dez"},  dez,  m_acc[d] / 10);
        check_val({p, ".uni"},  uni,  m_acc[d] % 10);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_dut(0, a1, b1, te1, busy1, done1, ovf1, dez1, uni1);
        check_dut(1, a3, b3, te3, busy3, done3, ovf3, dez3, uni3);
    endtask

    task automatic press(input logic p_op, input logic [3:0] p_sw, input int wait_cyc);
        op = p_op; sw = p_sw; enter = 1'b1;
        step();
        enter = 1'b0;
        repeat (wait_cyc) step();
    endtask

    int n_done1, n_done3;

    initial begin
        rst = 1'b1; enter = 1'b0; clear = 1'b0; op = 1'b0; sw = 4'd0;
        step();
        step();
        check_val("rst_acc", a1, 0);
        check_val("rst_busy", busy1, 0);
        check_val("rst_done", done1, 0);
        check_val("rst_ovf", ovf1, 0);
        rst = 1'b0;
        step();

        // 7 + 5 with explicit DONE timing on the SETTLE_CYCLES=1 instance.
        op = 1'b0; sw = 4'd7; enter = 1'b1;
        step();
        enter = 1'b0;
        check_val("t2_done_k", done1, 0);
        step();
        check_val("t2_done_k1", done1, 0);
        step();
        check_val("t2_done_k2", done1, 1);
        check_val("t2_acc_first", a1, 7);
        repeat (4) step();
        press(1'b0, 4'd5, 6);
        check_val("t2_acc", a1, 12);
        check_val("t2_dez", dez1, 1);
        check_val("t2_uni", uni1, 2);
        check_val("t2_acc3", a3, 12);

        press(1'b0, 4'd9, 6);
        check_val("t3_acc", a1, SAT ? 15 : 5);
        check_val("t3_ovf", ovf1, 1);

        clear = 1'b1; step(); clear = 1'b0; step();
        check_val("clr_acc", a1, 0);
        op = 1'b1; sw = 4'd3; enter = 1'b1;
        step();
        enter = 1'b0;
        check_val("t4_te_exec", te1, 1);
        check_val("t4_busy", busy1, 1);
        repeat (6) step();
        check_val("t4_acc", a1, SAT ? 0 : 13);
        check_val("t4_ovf", ovf1, 1);
        check_val("t4_dez", dez1, SAT ? 0 : 1);
        check_val("t4_uni", uni1, SAT ? 0 : 3);

        // Second ENTER edge while busy must not start another operation.
        n_done1 = 0; n_done3 = 0;
        op = 1'b0; sw = 4'd1; enter = 1'b1;
        step(); n_done1 += done1; n_done3 += done3;
        enter = 1'b0;
        step(); n_done1 += done1; n_done3 += done3;
        enter = 1'b1;
        step(); n_done1 += done1; n_done3 += done3;
        enter = 1'b0;
        repeat (8) begin step(); n_done1 += done1; n_done3 += done3; end
        check_val("t5_one_done1", n_done1, 1);
        check_val("t5_one_done3", n_done3, 1);

        clear = 1'b1; enter = 1'b1; sw = 4'd4;
        step();
        clear = 1'b0; enter = 1'b0;
        check_val("t5_clr_acc", a1, 0);
        check_val("t5_clr_busy", busy1, 0);
        step();
        check_val("t5_clr_busy_next", busy1, 0);

        // Reset while the SETTLE_CYCLES=3 instance is in EXEC.
        press(1'b0, 4'd6, 6);
        op = 1'b0; sw = 4'd2; enter = 1'b1;
        step();
        enter = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t6_acc3", a3, 0);
        check_val("t6_busy3", busy3, 0);
        n_done3 = 0;
        repeat (6) begin step(); n_done3 += done3; end
        check_val("t6_no_done3", n_done3, 0);

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 29) == 0);
            enter = ($urandom_range(0, 2) == 0);
            op    = $urandom_range(0, 1);
            sw    = 4'($urandom_range(0, 15));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
